// File: rtl/nibble_serial_addsub.sv
// Signed add/subtract that reuses one 4-bit carry-lookahead slice, one nibble per clock, LSB first.
// Optional saturation on signed overflow is enabled by defining NIBBLE_SERIAL_ADDSUB_SAT_EN.
module nibble_serial_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovfl,
    output logic             cout,
    output logic             zero,
    output logic             neg
);
    localparam int unsigned NNIB = WIDTH / 4;
    localparam int unsigned CW   = $clog2(NNIB);
    localparam int unsigned AW   = WIDTH - 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [AW-1:0]   acc;

    logic [3:0]       g_c;
    logic [3:0]       p_c;
    logic [4:0]       c_c;
    logic [3:0]       sum_c;
    logic [WIDTH-1:0] raw_c;
    logic             ovf_c;
    logic [WIDTH-1:0] res_c;

    // 4-bit carry-lookahead slice on the low nibble of the operand shift registers
    always_comb begin
        g_c    = a_sh[3:0] & b_sh[3:0];
        p_c    = a_sh[3:0] ^ b_sh[3:0];
        c_c[0] = carry;
        c_c[1] = g_c[0] | (p_c[0] & carry);
        c_c[2] = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & carry);
        c_c[3] = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
               | (p_c[2] & p_c[1] & p_c[0] & carry);
        c_c[4] = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
               | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
               | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & carry);
        sum_c  = p_c ^ c_c[3:0];
    end

    // Full-width view: only meaningful on the last nibble, where the MSBs sit in the slice
    always_comb begin
        raw_c = {sum_c, acc};
        ovf_c = (a_sh[3] == b_sh[3]) & (sum_c[3] != a_sh[3]);
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
        if (ovf_c) begin
            res_c = a_sh[3] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_c = raw_c;
        end
`else
        res_c = raw_c;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            result <= '0;
            ovfl   <= 1'b0;
            cout   <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            done   <= 1'b0;
            ready  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    acc   <= AW'(raw_c >> 4);
                    carry <= c_c[4];
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(NNIB - 1)) begin
                        result <= res_c;
                        ovfl   <= ovf_c;
                        cout   <= c_c[4];
                        zero   <= (res_c == '0);
                        neg    <= res_c[WIDTH-1];
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed scoreboard bench for nibble_serial_addsub (WIDTH=16); honours NIBBLE_SERIAL_ADDSUB_SAT_EN.
module tb_nibble_serial_addsub;
    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] res;
        logic         v;
        logic         c;
        logic         z;
        logic         n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         ovfl;
    logic         cout;
    logic         zero;
    logic         neg;

    exp_t         sb[$];
    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [W-1:0] last_res = '0;

    nibble_serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .ovfl   (ovfl),
        .cout   (cout),
        .zero   (zero),
        .neg    (neg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_fail);
        $fatal(1, "watchdog");
    end

    // Reference built from whole-word signed/unsigned arithmetic
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        int   sx;
        int   sy;
        int   rs;
        sx    = int'($signed(x));
        sy    = int'($signed(y));
        rs    = s ? (sx - sy) : (sx + sy);
        e.v   = (rs > 32767) || (rs < -32768);
        e.c   = s ? (x >= y) : ((32'(x) + 32'(y)) > 32'h0000_FFFF);
        e.res = 16'(rs);
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
        if (e.v) e.res = (rs > 0) ? 16'h7FFF : 16'h8000;
`endif
        e.z   = (e.res == 16'h0000);
        e.n   = e.res[W-1];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        check({tag, " sb depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " result"}, 32'(result), 32'(e.res));
            check({tag, " ovfl"}, 32'(ovfl), 32'(e.v));
            check({tag, " cout"}, 32'(cout), 32'(e.c));
            check({tag, " zero"}, 32'(zero), 32'(e.z));
            check({tag, " neg"}, 32'(neg), 32'(e.n));
            last_res = e.res;
        end
    endtask

    // One accepted operation with latency / ready-window / single-pulse checks
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts);
        int done_at;
        int ndone;
        int k;
        check({tag, " ready idle"}, 32'(ready), 32'd1);
        a     = ta;
        b     = tbv;
        sub   = ts;
        start = 1'b1;
        sb.push_back(model(ta, tbv, ts));
        tick;
        start = 1'b0;
        a     = ~ta;
        b     = ta ^ tbv;
        sub   = ~ts;
        check({tag, " ready low"}, 32'(ready), 32'd0);
        done_at = -1;
        ndone   = 0;
        k       = 0;
        while (k < 20 && ready !== 1'b1) begin
            tick;
            k++;
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = k;
                pop_compare(tag);
            end
        end
        check({tag, " latency"}, 32'(done_at), 32'd4);
        check({tag, " done pulses"}, 32'(ndone), 32'd1);
        check({tag, " ready low cycles"}, 32'(k), 32'd5);
        check({tag, " result held"}, 32'(result), 32'(last_res));
    endtask

    initial begin
        int acc_prev;
        logic prev_done;
        int ndone;

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        tick;
        tick;
        rst = 1'b0;
        tick;
        check("reset ready", 32'(ready), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset flags", {28'd0, ovfl, cout, zero, neg}, 32'd0);

        do_op("add 1234+1111", 16'h1234, 16'h1111, 1'b0);
        do_op("add 7fff+0001", 16'h7FFF, 16'h0001, 1'b0);
        do_op("sub 0005-0005", 16'h0005, 16'h0005, 1'b1);
        do_op("add ffff+0001", 16'hFFFF, 16'h0001, 1'b0);
        do_op("sub 0003-0005", 16'h0003, 16'h0005, 1'b1);
        do_op("add 8000+8000", 16'h8000, 16'h8000, 1'b0);
        do_op("sub 7fff-ffff", 16'h7FFF, 16'hFFFF, 1'b1);
        do_op("sub 8000-0001", 16'h8000, 16'h0001, 1'b1);

        // Abort an operation in its second RUN cycle with an async reset
        check("abort ready idle", 32'(ready), 32'd1);
        a     = 16'h00FF;
        b     = 16'h0001;
        sub   = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        check("abort ready", 32'(ready), 32'd1);
        check("abort done", 32'(done), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort flags", {28'd0, ovfl, cout, zero, neg}, 32'd0);
        tick;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (done === 1'b1) ndone++;
        end
        check("abort no done", 32'(ndone), 32'd0);
        last_res = '0;
        do_op("post-rst 0002+0003", 16'h0002, 16'h0003, 1'b0);

        // start held high while operands change every cycle
        acc_prev  = -1;
        prev_done = 1'b0;
        start     = 1'b1;
        for (int i = 0; i < 31; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            sub = 1'($urandom);
            if (ready === 1'b1) begin
                sb.push_back(model(a, b, sub));
                if (acc_prev >= 0) check("b2b period", 32'(i - acc_prev), 32'd6);
                acc_prev = i;
            end
            tick;
            if (done === 1'b1) begin
                check("b2b single done", 32'(prev_done), 32'd0);
                pop_compare("b2b");
            end else begin
                check("b2b hold", 32'(result), 32'(last_res));
            end
            prev_done = done;
        end
        start = 1'b0;
        for (int k = 0; k < 12 && sb.size() > 0; k++) begin
            tick;
            if (done === 1'b1) pop_compare("b2b drain");
        end
        check("b2b drained", 32'(sb.size()), 32'd0);
        for (int k = 0; k < 4 && ready !== 1'b1; k++) tick;

        do_op("add 0f0f+f0f1", 16'h0F0F, 16'hF0F1, 1'b0);

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle signed adder/subtractor that reuses one 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first.
- Serves ALU paths where area matters more than latency.
- Takes operands through a start/ready handshake and returns the result with a done pulse and Z/V/N/C flags for the flag register.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NNIB, WIDTH/4, derived; number of RUN cycles per operation. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- sub  input  1  0 = A+B, 1 = A-B; captured with start
- a  input  WIDTH  operand A (two's complement); captured with start
- b  input  WIDTH  operand B (two's complement); captured with start
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse; result and flags valid
- result  output  WIDTH  sum/difference; held until the next accepted start
- ovfl  output  1  signed overflow (V)
- cout  output  1  final carry out; for sub, 1 = no borrow
- zero  output  1  result == 0 (Z)
- neg  output  1  result[WIDTH-1] (N)

Behaviour:
- Reset (async, any state): state=IDLE, nibble count=0, carry=0, result=0, ovfl=cout=zero=neg=0, done=0, ready=1. Any in-flight operation is discarded and no done is issued for it.
- States:
  - IDLE: ready=1. On start=1, latch a, b XOR {WIDTH{sub}}, and carry=sub; count=0; go to RUN.
  - RUN: ready=0. Each edge adds the low nibble of the A and B shift registers plus carry through the 4-bit slice. The sum nibble shifts into the top of the accumulator, A and B shift right by 4, carry updates, count increments. On the edge that processes nibble NNIB-1, capture the final carry, compute overflow, load result and flags, and go to DONE.
  - DONE: done=1 for exactly one cycle, ready=0; then return to IDLE.
- Latency: start sampled at edge 0 → done high in the cycle following edge NNIB (NNIB cycles after acceptance; 4 for WIDTH=16). Throughput: one operation per NNIB+2 cycles.
- start while ready=0 is ignored, not queued. Operands may change freely after acceptance.
- Overflow: ovfl = (a_msb == bx_msb) & (sum_msb != a_msb), where bx is the inverted B for sub, taken from the last nibble.
- cout = carry out of the last nibble.
- zero and neg are computed on the final, post-saturation result.
- result, ovfl, cout, zero, neg change only on the DONE-entry edge or on reset; they are stable at all other times.
- Wrap-around: without saturation, the result is modulo 2^WIDTH.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDSUB_SAT_EN.
- Defined: on overflow, result saturates to 0x7FFF (positive overflow, a_msb=0) or 0x8000 (negative overflow, a_msb=1), sign-extended per WIDTH. ovfl still reports 1; cout is unchanged.
- Undefined: result is the raw wrapped sum; no saturation logic is synthesized.

Test Plan (WIDTH=16):
- add 0x1234 + 0x1111 → result 0x2345, ovfl=0, cout=0, zero=0, neg=0; done exactly 4 cycles after the start edge; ready low for 5 cycles.
- add 0x7FFF + 0x0001 → ovfl=1, neg per result. Without SAT_EN: result 0x8000. With SAT_EN: result 0x7FFF, neg=0.
- sub 0x0005 - 0x0005 → result 0x0000, zero=1, cout=1, ovfl=0.
- sub 0x8000 - 0x0001 → ovfl=1. Without SAT_EN: result 0x7FFF. With SAT_EN: result 0x8000, neg=1.
- start held high continuously with changing operands → only the operand captured while ready=1 is used. Ops are back-to-back every 6 cycles, each done is a single cycle, and result is held between ops.
- rst pulsed during the second RUN cycle of 0x00FF + 0x0001 → all outputs 0 and ready=1 immediately, with no done. The next op, 0x0002 + 0x0003, gives 0x0005.
